// File: rtl/led_mode_ctrl.sv
// Two-button / two-LED blink-mode controller: sync + debounce buttons, one-shot presses, per-LED mode FSM.
// Pin fall to mode change: 2 + 2^DB_BITS + 1 clocks; nLED follows one clock later. No flow control.
module led_mode_ctrl #(
    parameter int CNT_W    = 23,
    parameter int SLOW_BIT = 22,
    parameter int FAST_BIT = 20,
    parameter int DB_BITS  = 16
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       nPB0,
    input  logic       nPB1,
    output logic       nLED0,
    output logic       nLED1,
    output logic [1:0] mode0,
    output logic [1:0] mode1
);

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        SLOW = 2'b01,
        FAST = 2'b10,
        ON   = 2'b11
    } mode_t;

    localparam logic [DB_BITS-1:0] DB_MAX  = '1;
    localparam logic [DB_BITS-1:0] DB_ONE  = 1;
    localparam logic [CNT_W-1:0]   CNT_ONE = 1;

    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_sync_a;
    logic [1:0]         r_sync_b;
    logic [1:0]         r_db;
    logic [1:0]         r_press;
    logic [DB_BITS-1:0] r_db_cnt [2];
    logic [1:0]         w_pin;

    mode_t r_mode0, r_mode1;
    mode_t w_mode0_nxt, w_mode1_nxt;
    logic  w_resync;
    logic  r_nled0, r_nled1;

    assign w_pin = {nPB1, nPB0};

    function automatic mode_t f_adv(input mode_t m);
        case (m)
            OFF:     return SLOW;
            SLOW:    return FAST;
            FAST:    return ON;
            default: return OFF;
        endcase
    endfunction

    function automatic logic f_led(input mode_t m, input logic slow, input logic fast);
        case (m)
            OFF:     return 1'b0;
            SLOW:    return slow;
            FAST:    return fast;
            default: return 1'b1;
        endcase
    endfunction

    // Press fires on the same edge db falls, so the mode moves on the following edge.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_sync_a <= 2'b11;
            r_sync_b <= 2'b11;
            r_db     <= 2'b11;
            r_press  <= 2'b00;
            for (int g = 0; g < 2; g++) begin
                r_db_cnt[g] <= '0;
            end
        end else begin
            r_sync_a <= w_pin;
            r_sync_b <= r_sync_a;
            for (int g = 0; g < 2; g++) begin
                r_press[g] <= 1'b0;
                if (r_sync_b[g] == r_db[g]) begin
                    r_db_cnt[g] <= '0;
                end else if (r_db_cnt[g] == DB_MAX) begin
                    r_db[g]     <= r_sync_b[g];
                    r_db_cnt[g] <= '0;
                    r_press[g]  <= r_db[g];
                end else begin
                    r_db_cnt[g] <= r_db_cnt[g] + DB_ONE;
                end
            end
        end
    end

    always_comb begin
        w_mode0_nxt = r_mode0;
        w_mode1_nxt = r_mode1;
        w_resync    = 1'b0;
        if (r_press[0] && r_press[1]) begin
            w_mode0_nxt = SLOW;
            w_mode1_nxt = SLOW;
            w_resync    = 1'b1;
        end else begin
            if (r_press[0]) w_mode0_nxt = f_adv(r_mode0);
            if (r_press[1]) w_mode1_nxt = f_adv(r_mode1);
        end
    end

    // LED1 slow blink runs in antiphase with LED0.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_cnt   <= '0;
            r_mode0 <= SLOW;
            r_mode1 <= SLOW;
            r_nled0 <= 1'b1;
            r_nled1 <= 1'b1;
        end else begin
            r_cnt   <= w_resync ? '0 : r_cnt + CNT_ONE;
            r_mode0 <= w_mode0_nxt;
            r_mode1 <= w_mode1_nxt;
            r_nled0 <= ~f_led(r_mode0, r_cnt[SLOW_BIT], r_cnt[FAST_BIT]);
            r_nled1 <= ~f_led(r_mode1, ~r_cnt[SLOW_BIT], r_cnt[FAST_BIT]);
        end
    end

    assign nLED0 = r_nled0;
    assign nLED1 = r_nled1;
    assign mode0 = r_mode0;
    assign mode1 = r_mode1;

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Per-LED blink-mode controller for the two-button/two-LED board I/O. It synchronizes and debounces the active-low pushbuttons nPB0/nPB1 and turns each clean press into a one-shot event. A 4-state mode FSM per LED consumes those events. The block drives the active-low LEDs from an internal free-running prescaler and replaces the fixed slow/fast button-select logic in top.

Parameters:
CNT_W, 23, prescaler width; must be > SLOW_BIT.
SLOW_BIT, 22, prescaler bit used for the slow blink.
FAST_BIT, 20, prescaler bit used for the fast blink; must be < SLOW_BIT.
DB_BITS, 16, debounce counter width; stability window N = 2^DB_BITS cycles.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
nRst  input  1  synchronous reset, active-low.
nPB0  input  1  pushbutton 0, asynchronous, active-low.
nPB1  input  1  pushbutton 1, asynchronous, active-low.
nLED0  output  1  LED 0, active-low, registered.
nLED1  output  1  LED 1, active-low, registered.
mode0  output  2  current LED0 mode (status/debug).
mode1  output  2  current LED1 mode (status/debug).

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low (nRst sampled on the rising edge of clk). While nRst=0 at an edge:
  - prescaler cnt=0; sync flops=1; debounced state db=1; debounce counters=0; press pulses=0.
  - mode0=mode1=SLOW (01); nLED0=nLED1=1 (LEDs off).
  - Reset asserted mid-debounce or mid-blink discards all progress.
- Prescaler: CNT_W-bit up-counter, +1 per cycle, wraps from all-ones to 0.
- Synchronizer: 2 flops per button. The raw pin reaches sync output 2 edges after it changes.
- Debouncer, per button:
  - If sync==db, the counter clears to 0.
  - Otherwise the counter increments. On the Nth consecutive mismatch cycle (counter == N-1), db takes the sync value and the counter clears.
  - Any glitch shorter than N cycles leaves db unchanged.
- Press event: pressX is a 1-cycle registered pulse, asserted the cycle after dbX goes 1->0.
  - Release (0->1) generates no event.
  - A held button generates no repeat.
- Mode FSM, per LED; encoding OFF=00, SLOW=01, FAST=10, ON=11.
  - On pressX alone: OFF->SLOW->FAST->ON->OFF, updating at the edge where pressX=1.
  - Simultaneous press0 and press1 in the same cycle: both modes go to SLOW and cnt clears to 0 (resync); no individual advance occurs.
  - A press0 one cycle apart from press1 is two individual advances.
- LED drive, registered, 1 cycle after mode/cnt:
  - led0: OFF 0; SLOW cnt[SLOW_BIT]; FAST cnt[FAST_BIT]; ON 1.
  - led1: same, except SLOW uses ~cnt[SLOW_BIT] (antiphase with LED0).
  - nLEDx = ~ledX.
- End-to-end latency from pin fall to mode change: 2 (sync) + N (debounce) + 1 (press reg) edges. nLED then reflects the new mode 1 edge later.

Test Plan:
(Bench parameters: CNT_W=4, SLOW_BIT=3, FAST_BIT=1, DB_BITS=2, so N=4.)
- Reset: hold nRst=0 for 3 cycles with nPB0=nPB1=0 -> nLED0=nLED1=1, mode0=mode1=01, no press pulse. Release nRst -> nLED0 follows ~cnt[3] and nLED1 follows cnt[3], one cycle delayed, 8-cycle half-period.
- Clean press: drive nPB0=0 for 20 cycles -> mode0 goes 01->10 exactly 7 edges after the pin falls, then nLED0 toggles every 2 cycles. Release and press again -> 11, nLED0=0 constant. Press again -> 00, nLED0=1.
- Glitch rejection: pulse nPB1=0 for 3 cycles, 5 times with 1-cycle gaps -> mode1 stays 01, no press1. Then hold for 6 cycles -> mode1=10.
- Held button: hold nPB0=0 for 100 cycles -> exactly one mode0 advance.
- Simultaneous press: with mode0=11 and mode1=00, fall both pins on the same cycle -> both modes=01 and cnt=0 on the same edge. Stagger the falls by 1 cycle -> mode0=00, mode1=01 via individual advances.
- Reset mid-debounce: nPB0 low for 3 cycles, then nRst=0 for 1 cycle, with nPB0 still low afterwards -> no advance until a fresh 2+4 cycles after reset release. mode0 returns to 01 at reset.
